// File: rtl/bram_fwd.sv
// Simple dual-port BRAM: byte-write port A, read port B with forwarding,
// selectable read latency and a sequential clear engine.
module bram_fwd #(
    parameter int LEN_DATA      = 32,
    parameter int LEN_ADDR      = 8,
    parameter int byteWidth     = 8,
    parameter int READ_LAT      = 1,
    parameter int BYPASS        = 1,
    parameter int INIT_ON_RESET = 1,
    localparam int NB           = LEN_DATA / byteWidth
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ena,
    input  logic [NB-1:0]       wea,
    input  logic [LEN_ADDR-1:0] addra,
    input  logic [LEN_DATA-1:0] dina,
    input  logic                enb,
    input  logic [LEN_ADDR-1:0] addrb,
    output logic [LEN_DATA-1:0] doutb,
    output logic                rvalid,
    input  logic                init_req,
    output logic                init_busy
);

    localparam int DEPTH = 2 ** LEN_ADDR;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [LEN_ADDR-1:0] LAST = {LEN_ADDR{1'b1}};

    logic [LEN_DATA-1:0] ram [DEPTH];
    logic [0:0]          state;
    logic [LEN_ADDR-1:0] cnt;
    logic                busy;
    logic                wr_en;
    logic [LEN_DATA-1:0] stored;
    logic [LEN_DATA-1:0] fwd;
    logic [LEN_DATA-1:0] rd_word;
    logic [LEN_DATA-1:0] rd1;
    logic                v1;

    assign busy      = (state == CLEAR);
    assign init_busy = busy;
    assign wr_en     = ena & ~busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (init_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Array has no reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (resetn && busy) begin
            ram[cnt] <= '0;
        end else if (resetn && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    ram[addra][i*byteWidth +: byteWidth] <=
                        dina[i*byteWidth +: byteWidth];
                end
            end
        end
    end

    always_comb begin
        stored = ram[addrb];
        fwd    = stored;
        if (BYPASS != 0 && wr_en && addra == addrb) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    fwd[i*byteWidth +: byteWidth] =
                        dina[i*byteWidth +: byteWidth];
                end
            end
        end
        rd_word = busy ? '0 : fwd;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd1 <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= enb;
            if (enb) begin
                rd1 <= rd_word;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [LEN_DATA-1:0] rd2;
            logic                v2;

            // Output register only moves on a valid stage-1 result.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    rd2 <= '0;
                    v2  <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        rd2 <= rd1;
                    end
                end
            end

            assign doutb  = rd2;
            assign rvalid = v2;
        end else begin : g_lat1
            assign doutb  = rd1;
            assign rvalid = v1;
        end
    endgenerate

endmodule

// File: doc/bram_fwd.md
Name: bram_fwd

Overview:
- Single-clock simple dual-port block RAM for cache tag/data arrays; successor to the basic byte-write BRAM.
- Port A writes with per-byte enables; port B reads.
- Adds selectable read latency, same-cycle read-during-write forwarding with byte merge, a read-valid strobe, and a sequential clear engine run on reset or on request.

Parameters:
LEN_DATA, 32, data width in bits; must be a multiple of byteWidth
LEN_ADDR, 8, address width; DEPTH = 2**LEN_ADDR
byteWidth, 8, bits per write-enable lane; NB = LEN_DATA/byteWidth
READ_LAT, 1, read latency in cycles; legal values 1 or 2 only (2 adds an output register)
BYPASS, 1, 1 = write-first forwarding on same-address collision; 0 = read-first (old data)
INIT_ON_RESET, 1, 1 = clear engine starts on reset release; 0 = idle after reset

Ports:
clk  in  1  single clock
resetn  in  1  reset; asynchronous, active-low
ena  in  1  port A write enable
wea  in  NB  per-byte write strobes, qualified by ena
addra  in  LEN_ADDR  write address
dina  in  LEN_DATA  write data
enb  in  1  port B read enable
addrb  in  LEN_ADDR  read address
doutb  out  LEN_DATA  read data
rvalid  out  1  one-cycle strobe: doutb carries the result of a read issued READ_LAT cycles earlier
init_req  in  1  request a full-array clear
init_busy  out  1  clear engine active

Behaviour:
- Reset (resetn=0, async):
  - doutb=0, rvalid=0, all pipeline valid/data regs = 0, clear counter = 0.
  - Clear FSM goes to CLEAR if INIT_ON_RESET=1, else IDLE; init_busy reflects that state immediately.
  - Array contents are not reset by resetn; only the clear engine zeroes them.
- Write (IDLE only):
  - At posedge with ena=1, ram[addra] byte i <= dina byte i for each wea[i]=1; other bytes unchanged.
  - ena=1 with wea=0 is a no-op.
- Read:
  - Stage 1: at posedge with enb=1, capture rd1 = ram[addrb] (or the merged word below) and set v1=1; with enb=0, v1=0 and rd1 holds.
  - READ_LAT=1: doutb=rd1, rvalid=v1.
  - READ_LAT=2: stage 2 loads rd1 into doutb only when v1=1; rvalid=v1 delayed one cycle; doutb holds otherwise.
  - doutb never changes without a matching rvalid pulse.
- Collision (same cycle ena=1, enb=1, addra==addrb):
  - BYPASS=1: captured word byte i = wea[i] ? dina byte i : stored byte i.
  - BYPASS=0: captured word = stored word before the write.
  - The write commits normally in both modes.
  - Write at cycle t, read of the same address at t+1 or later returns the new data; no forwarding is needed.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on init_req=1 at posedge; counter := 0.
  - CLEAR: each cycle writes all-zero to ram[cnt] and increments cnt. At cnt==DEPTH-1 the last entry is written and the FSM returns to IDLE next edge.
  - init_busy=1 for exactly DEPTH cycles.
  - init_req while in CLEAR is ignored (no restart).
  - Port A writes while init_busy=1 are dropped; no queuing.
  - Reads issued while init_busy=1 still produce rvalid, but the captured data is forced to 0.
  - resetn asserted mid-clear restarts per reset rules (counter 0).
- Widths: counter is LEN_ADDR bits and does not wrap past DEPTH-1; NB derived, no partial lanes.

Test Plan:
- Reset clear, LEN_ADDR=4, INIT_ON_RESET=1: release resetn -> init_busy high exactly 16 cycles. Then read every address -> doutb=0 each, rvalid pulse 1 cycle after each enb.
- Byte write, READ_LAT=1: write addr 3 dina=0xAABBCCDD wea=1111, then addr 3 dina=0x11223344 wea=0101, then read addr 3 -> doutb=0xAA22CC44 one cycle after enb, rvalid=1 for one cycle.
- Collision, addr 5 pre-holding 0x01020304; same-cycle write dina=0xFFFFFFFF wea=1000 and read addr 5 -> BYPASS=1: doutb=0xFF020304; BYPASS=0: doutb=0x01020304. A following read returns 0xFF020304 in both modes.
- READ_LAT=2 back-to-back reads of addrs 1,2,3 holding 0x10,0x20,0x30 -> doutb=0x10,0x20,0x30 on cycles t+2, t+3, t+4 with rvalid high all three cycles; with enb idle, doutb holds 0x30 and rvalid=0.
- init_req mid-operation: fill addr 7=0x55; pulse init_req, then write addr 9=0x66 during busy; pulse init_req again during busy -> busy lasts DEPTH cycles with no restart. After clear, addr 7 and addr 9 read 0; a read issued during busy returns 0 with rvalid=1.
- Reset mid-clear: assert resetn low at cycle 5 of CLEAR -> doutb=0, rvalid=0 immediately. On release, a full DEPTH-cycle clear runs again.
